// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller: issues one request per load/store,
// stalls the pipeline until ack or timeout, and reports misaligned accesses.
module mem_access_ctrl #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        o_stall,
  output logic [31:0] o_load_data,
  output logic        o_load_valid,
  output logic        o_misaligned,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LIMIT = 8'(ACK_TIMEOUT - 1);

  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] cnt_r;
  logic       req_s;
  logic       aligned_s;
  logic       start_s;
  logic       busy_s;
  logic       ack_s;
  logic       timeout_hit_s;

  // Decode of the incoming request and the BUSY-state completion events.
  always_comb begin
    req_s         = i_MemRead | i_MemWrite;
    aligned_s     = (i_addr[1:0] == 2'b00);
    start_s       = (state_r == ST_IDLE) && req_s && aligned_s;
    busy_s        = (state_r == ST_BUSY);
    ack_s         = busy_s && mem_ack;
    // Ack has priority: a timeout only fires in a cycle without ack.
    timeout_hit_s = busy_s && !mem_ack && (cnt_r == CNT_LIMIT);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_next_s = aligned_s ? ST_BUSY : ST_DONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (ack_s || timeout_hit_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; reset masks the combinational stall/misaligned paths.
  always_comb begin
    mem_req      = busy_s;
    o_stall      = 1'b0;
    o_misaligned = 1'b0;
    if (reset) begin
      o_stall      = 1'b0;
      o_misaligned = 1'b0;
    end else begin
      o_stall      = start_s || busy_s;
      o_misaligned = (state_r == ST_IDLE) && req_s && !aligned_s;
    end
  end

  // Request attributes are captured once on entry to BUSY and held throughout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else if (start_s) begin
      mem_we    <= i_MemWrite;
      mem_addr  <= i_addr;
      mem_wdata <= i_wdata;
    end else begin
      mem_we    <= mem_we;
      mem_addr  <= mem_addr;
      mem_wdata <= mem_wdata;
    end
  end

  // Saturating count of BUSY cycles without ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= 8'd0;
    end else if (start_s) begin
      cnt_r <= 8'd0;
    end else if (busy_s && !mem_ack && (cnt_r != 8'hFF)) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Completion results; the pulses land exactly in the DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_load_data  <= 32'd0;
      o_load_valid <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_load_valid <= ack_s && !mem_we;
      o_timeout    <= timeout_hit_s;
      if (ack_s && !mem_we) begin
        o_load_data <= mem_rdata;
      end else if (timeout_hit_s) begin
        o_load_data <= 32'd0;
      end else begin
        o_load_data <= o_load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (ACK_TIMEOUT = 4).
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        i_MemRead;
  logic        i_MemWrite;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        o_stall;
  logic [31:0] o_load_data;
  logic        o_load_valid;
  logic        o_misaligned;
  logic        o_timeout;

  int check_cnt;
  int error_cnt;
  int req_cycles;

  mem_access_ctrl #(.ACK_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_MemRead    (i_MemRead),
    .i_MemWrite   (i_MemWrite),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .o_stall      (o_stall),
    .o_load_data  (o_load_data),
    .o_load_valid (o_load_valid),
    .o_misaligned (o_misaligned),
    .o_timeout    (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt = check_cnt + 1;
    if (got !== exp) begin
      error_cnt = error_cnt + 1;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    check_cnt  = 0;
    error_cnt  = 0;
    req_cycles = 0;
    reset      = 1'b1;
    i_MemRead  = 1'b1;
    i_MemWrite = 1'b0;
    i_addr     = 32'h0000_0100;
    i_wdata    = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    repeat (2) @(posedge clk);
    #3;
    check_val("rst_mem_req",    32'(mem_req),      32'd0);
    check_val("rst_mem_we",     32'(mem_we),       32'd0);
    check_val("rst_mem_addr",   mem_addr,          32'd0);
    check_val("rst_mem_wdata",  mem_wdata,         32'd0);
    check_val("rst_load_data",  o_load_data,       32'd0);
    check_val("rst_load_valid", 32'(o_load_valid), 32'd0);
    check_val("rst_timeout",    32'(o_timeout),    32'd0);
    check_val("rst_stall",      32'(o_stall),      32'd0);

    // Aligned load at 0x100, ack in the third BUSY cycle.
    tick(); reset = 1'b0; #1;
    check_val("ld_idle_stall", 32'(o_stall), 32'd1);
    check_val("ld_idle_req",   32'(mem_req), 32'd0);
    tick(); #1;
    check_val("ld_b1_req",  32'(mem_req), 32'd1);
    check_val("ld_b1_addr", mem_addr,     32'h0000_0100);
    check_val("ld_b1_we",   32'(mem_we),  32'd0);
    check_val("ld_b1_stall", 32'(o_stall), 32'd1);
    tick(); #1;
    check_val("ld_b2_stall", 32'(o_stall), 32'd1);
    tick(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    check_val("ld_b3_stall", 32'(o_stall), 32'd1);
    tick(); mem_ack = 1'b0; mem_rdata = 32'h0; #1;
    check_val("ld_done_stall", 32'(o_stall),      32'd0);
    check_val("ld_done_req",   32'(mem_req),      32'd0);
    check_val("ld_done_valid", 32'(o_load_valid), 32'd1);
    check_val("ld_done_data",  o_load_data,       32'hDEAD_BEEF);
    tick(); i_MemRead = 1'b0; #1;
    check_val("ld_idle_valid", 32'(o_load_valid), 32'd0);
    check_val("ld_hold_data",  o_load_data,       32'hDEAD_BEEF);

    // Store at 0x204 acked in the first BUSY cycle; inputs change during BUSY.
    i_MemWrite = 1'b1; i_addr = 32'h0000_0204; i_wdata = 32'h1234_5678; #1;
    check_val("st_idle_stall", 32'(o_stall), 32'd1);
    tick(); i_addr = 32'hFFFF_FFF0; i_wdata = 32'h0; mem_ack = 1'b1; #1;
    check_val("st_b1_we",    32'(mem_we), 32'd1);
    check_val("st_b1_addr",  mem_addr,    32'h0000_0204);
    check_val("st_b1_wdata", mem_wdata,   32'h1234_5678);
    check_val("st_b1_stall", 32'(o_stall), 32'd1);
    tick(); mem_ack = 1'b0; #1;
    check_val("st_done_stall", 32'(o_stall),      32'd0);
    check_val("st_done_valid", 32'(o_load_valid), 32'd0);
    check_val("st_done_req",   32'(mem_req),      32'd0);
    tick(); i_MemWrite = 1'b0; #1;

    // Misaligned load at 0x103 with a stray ack while idle.
    i_MemRead = 1'b1; i_addr = 32'h0000_0103; mem_ack = 1'b1; mem_rdata = 32'h5555_5555; #1;
    check_val("mis_pulse", 32'(o_misaligned), 32'd1);
    check_val("mis_stall", 32'(o_stall),      32'd0);
    check_val("mis_req",   32'(mem_req),      32'd0);
    tick(); mem_ack = 1'b0; #1;
    check_val("mis_done_pulse", 32'(o_misaligned), 32'd0);
    check_val("mis_done_req",   32'(mem_req),      32'd0);
    check_val("mis_done_valid", 32'(o_load_valid), 32'd0);
    check_val("mis_done_data",  o_load_data,       32'hDEAD_BEEF);
    tick(); i_MemRead = 1'b0; #1;

    // Reset during the second BUSY cycle, then a late ack.
    i_MemRead = 1'b1; i_addr = 32'h0000_0300;
    tick(); #1;
    check_val("rb_b1_req", 32'(mem_req), 32'd1);
    tick(); #1;
    reset = 1'b1; #1;
    check_val("rb_async_req",  32'(mem_req),   32'd0);
    check_val("rb_async_data", o_load_data,    32'd0);
    check_val("rb_async_addr", mem_addr,       32'd0);
    check_val("rb_async_stall", 32'(o_stall),  32'd0);
    i_MemRead = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick(); tick(); reset = 1'b0;
    tick(); #1;
    check_val("rb_late_req",   32'(mem_req),      32'd0);
    check_val("rb_late_valid", 32'(o_load_valid), 32'd0);
    check_val("rb_late_data",  o_load_data,       32'd0);
    mem_ack = 1'b0;

    // Read and write both set at 0x40: write wins; stall proves FSM was IDLE.
    i_MemRead = 1'b1; i_MemWrite = 1'b1; i_addr = 32'h0000_0040; i_wdata = 32'h0BAD_F00D; #1;
    check_val("rw_idle_stall", 32'(o_stall), 32'd1);
    tick(); mem_ack = 1'b1; mem_rdata = 32'h1111_1111; #1;
    check_val("rw_we",    32'(mem_we), 32'd1);
    check_val("rw_addr",  mem_addr,    32'h0000_0040);
    check_val("rw_wdata", mem_wdata,   32'h0BAD_F00D);
    tick(); mem_ack = 1'b0; #1;
    check_val("rw_valid", 32'(o_load_valid), 32'd0);
    check_val("rw_data",  o_load_data,       32'd0);
    tick(); i_MemRead = 1'b0; i_MemWrite = 1'b0; #1;

    // Acked read followed back-to-back by a load that times out.
    i_MemRead = 1'b1; i_addr = 32'h0000_0080;
    tick(); mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5; #1;
    tick(); mem_ack = 1'b0; #1;
    check_val("b2b_valid", 32'(o_load_valid), 32'd1);
    check_val("b2b_data",  o_load_data,       32'hA5A5_A5A5);
    tick(); i_addr = 32'h0000_0084; #1;
    check_val("b2b_restall", 32'(o_stall), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      if (o_timeout) break;
      if (mem_req) req_cycles = req_cycles + 1;
    end
    check_val("to_pulse",      32'(o_timeout),    32'd1);
    check_val("to_req_cycles", 32'(req_cycles),   32'd4);
    check_val("to_data",       o_load_data,       32'd0);
    check_val("to_valid",      32'(o_load_valid), 32'd0);
    check_val("to_req_done",   32'(mem_req),      32'd0);
    tick(); i_MemRead = 1'b0; #1;
    check_val("to_pulse_end", 32'(o_timeout), 32'd0);
    check_val("to_idle_stall", 32'(o_stall),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
